// File: rtl/scan_mux.sv
// scan_mux -- registered N_CH-channel, W-bit selector with manual and
// auto-scan modes behind a valid/ready output handshake.
//
// Optional feature macro: SCAN_MUX_MASK_EN
//   When defined, adds the ch_mask input. Auto-scan then visits only the
//   channels whose mask bit is set. Manual mode ignores the mask.
//
// Parameters:
//   N_CH  - number of input channels (>= 2)
//   W     - bits per channel
//   SEL_W - select/index width, derived from N_CH (leave at default)
//   DWELL - accepted samples per channel in auto-scan (>= 1)
//
// Ports:
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   en        in   block enable
//   mode      in   0 = manual, 1 = auto-scan
//   sel       in   manual channel select
//   in_data   in   packed channels, channel k = in_data[k*W +: W]
//   ch_mask   in   per-channel scan enable (SCAN_MUX_MASK_EN only)
//   out_data  out  registered selected sample
//   out_sel   out  channel index of out_data
//   out_valid out  out_data/out_sel valid
//   out_ready in   consumer accepts when out_valid && out_ready
//   scan_wrap out  one-cycle pulse when auto-scan wraps back to the start
//   sel_err   out  high while the last manual load used sel >= N_CH
module scan_mux #(
  parameter int N_CH  = 4,
  parameter int W     = 1,
  parameter int SEL_W = $clog2(N_CH),
  parameter int DWELL = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              mode,
  input  logic [SEL_W-1:0]  sel,
  input  logic [N_CH*W-1:0] in_data,
`ifdef SCAN_MUX_MASK_EN
  input  logic [N_CH-1:0]   ch_mask,
`endif
  output logic [W-1:0]      out_data,
  output logic [SEL_W-1:0]  out_sel,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              scan_wrap,
  output logic              sel_err
);

  localparam int N_PAD = 1 << SEL_W;
  localparam int DW_W  = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DW_W-1:0]  DWELL_LAST = DW_W'(DWELL - 1);
  localparam logic [SEL_W-1:0] LAST_SEL   = SEL_W'(N_CH - 1);
  localparam logic [SEL_W:0]   N_CH_V     = (SEL_W + 1)'(N_CH);

  typedef enum logic [1:0] {IDLE, MANUAL, SCAN} state_t;

  state_t           state;
  logic [SEL_W-1:0] cur_sel;
  logic [DW_W-1:0]  dwell_cnt;

  // Channel table padded to a power of two: any select code above N_CH-1
  // reads zero, which is exactly the out-of-range manual result.
  logic [W-1:0] ch [N_PAD];

  genvar gi;
  generate
    for (gi = 0; gi < N_PAD; gi++) begin : g_ch
      if (gi < N_CH) begin : g_real
        assign ch[gi] = in_data[gi*W +: W];
      end else begin : g_pad
        assign ch[gi] = '0;
      end
    end
  endgenerate

  logic sel_oob;
  assign sel_oob = ({1'b0, sel} >= N_CH_V);

  // Scan index helpers:
  //   low_sel  - first channel of a fresh scan
  //   eff_sel  - channel loaded by this scan slot
  //   nxt_sel  - channel that follows eff_sel once its dwell completes
  //   nxt_wrap - moving to nxt_sel wraps the index
  //   scan_any - at least one channel is eligible for scanning
  logic [SEL_W-1:0] low_sel;
  logic [SEL_W-1:0] eff_sel;
  logic [SEL_W-1:0] nxt_sel;
  logic             nxt_wrap;
  logic             scan_any;

`ifdef SCAN_MUX_MASK_EN
  function automatic logic [SEL_W-1:0] ch_idx(input logic [SEL_W-1:0] base,
                                              input int off);
    ch_idx = SEL_W'((int'(base) + off) % N_CH);
  endfunction

  // Loops run from the far end down so the nearest set bit wins. If the
  // mask changed under cur_sel, eff_sel slides forward to the next enabled
  // channel instead of loading a masked one.
  always_comb begin
    low_sel  = '0;
    eff_sel  = cur_sel;
    nxt_sel  = cur_sel;
    scan_any = |ch_mask;
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (ch_mask[k]) low_sel = SEL_W'(k);
    end
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (ch_mask[ch_idx(cur_sel, k)]) eff_sel = ch_idx(cur_sel, k);
    end
    // Offset N_CH lands back on eff_sel itself: a single enabled channel
    // keeps being reselected and counts as a wrap every time.
    for (int k = N_CH; k >= 1; k--) begin
      if (ch_mask[ch_idx(eff_sel, k)]) nxt_sel = ch_idx(eff_sel, k);
    end
    nxt_wrap = (nxt_sel <= eff_sel);
  end
`else
  assign low_sel  = '0;
  assign eff_sel  = cur_sel;
  assign scan_any = 1'b1;
  assign nxt_wrap = (cur_sel == LAST_SEL);
  assign nxt_sel  = nxt_wrap ? '0 : cur_sel + 1'b1;
`endif

  // A load slot exists whenever the output register is empty or its
  // current sample is being accepted this cycle.
  logic slot;
  assign slot = !out_valid || out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cur_sel   <= '0;
      dwell_cnt <= '0;
      out_data  <= '0;
      out_sel   <= '0;
      out_valid <= 1'b0;
      scan_wrap <= 1'b0;
      sel_err   <= 1'b0;
    end else begin
      scan_wrap <= 1'b0;
      case (state)
        IDLE: begin
          out_valid <= 1'b0;
          if (en) begin
            if (mode) begin
              state     <= SCAN;
              cur_sel   <= low_sel;
              dwell_cnt <= '0;
            end else begin
              state <= MANUAL;
            end
          end
        end

        MANUAL, SCAN: begin
          if (!en) begin
            // Let a stalled sample drain before dropping to IDLE.
            if (slot) begin
              state     <= IDLE;
              out_valid <= 1'b0;
            end
          end else if (slot) begin
            if (mode != (state == SCAN)) begin
              // Mode switch consumes this slot; the first load in the new
              // mode happens on the following slot.
              out_valid <= 1'b0;
              if (mode) begin
                state     <= SCAN;
                cur_sel   <= low_sel;
                dwell_cnt <= '0;
              end else begin
                state <= MANUAL;
              end
            end else if (state == MANUAL) begin
              out_data  <= ch[sel];
              out_sel   <= sel;
              out_valid <= 1'b1;
              sel_err   <= sel_oob;
            end else if (scan_any) begin
              out_data  <= ch[eff_sel];
              out_sel   <= eff_sel;
              out_valid <= 1'b1;
              if (dwell_cnt == DWELL_LAST) begin
                dwell_cnt <= '0;
                cur_sel   <= nxt_sel;
                scan_wrap <= nxt_wrap;
              end else begin
                dwell_cnt <= dwell_cnt + 1'b1;
                cur_sel   <= eff_sel;
              end
            end else begin
              // Nothing eligible to scan: empty the output and wait.
              out_valid <= 1'b0;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_scan_mux.sv
// tb_scan_mux -- directed self-checking bench for scan_mux.
// Instances: dut_a (N_CH=4, W=1, DWELL=2), dut_b (N_CH=3, W=8, DWELL=1),
// dut_c (N_CH=4, W=1, DWELL=1; mask scan when SCAN_MUX_MASK_EN is defined).
module tb_scan_mux;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // dut_a
  logic       en_a, mode_a, ready_a;
  logic [1:0] sel_a;
  logic [3:0] in_a;
  logic [0:0] data_a;
  logic [1:0] osel_a;
  logic       valid_a, wrap_a, err_a;
  // dut_b
  logic        en_b, mode_b, ready_b;
  logic [1:0]  sel_b;
  logic [23:0] in_b;
  logic [7:0]  data_b;
  logic [1:0]  osel_b;
  logic        valid_b, wrap_b, err_b;
  // dut_c
  logic       en_c, mode_c, ready_c;
  logic [1:0] sel_c;
  logic [3:0] in_c;
  logic [0:0] data_c;
  logic [1:0] osel_c;
  logic       valid_c, wrap_c, err_c;
`ifdef SCAN_MUX_MASK_EN
  logic [3:0] mask_a = 4'hF;
  logic [2:0] mask_b = 3'h7;
  logic [3:0] mask_c = 4'hF;
`endif

  scan_mux #(.N_CH(4), .W(1), .DWELL(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en_a), .mode(mode_a), .sel(sel_a),
    .in_data(in_a),
`ifdef SCAN_MUX_MASK_EN
    .ch_mask(mask_a),
`endif
    .out_data(data_a), .out_sel(osel_a), .out_valid(valid_a),
    .out_ready(ready_a), .scan_wrap(wrap_a), .sel_err(err_a)
  );

  scan_mux #(.N_CH(3), .W(8), .DWELL(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en_b), .mode(mode_b), .sel(sel_b),
    .in_data(in_b),
`ifdef SCAN_MUX_MASK_EN
    .ch_mask(mask_b),
`endif
    .out_data(data_b), .out_sel(osel_b), .out_valid(valid_b),
    .out_ready(ready_b), .scan_wrap(wrap_b), .sel_err(err_b)
  );

  scan_mux #(.N_CH(4), .W(1), .DWELL(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .en(en_c), .mode(mode_c), .sel(sel_c),
    .in_data(in_c),
`ifdef SCAN_MUX_MASK_EN
    .ch_mask(mask_c),
`endif
    .out_data(data_c), .out_sel(osel_c), .out_valid(valid_c),
    .out_ready(ready_c), .scan_wrap(wrap_c), .sel_err(err_c)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int exp_sel_a [9] = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
  int exp_dat_a [9] = '{0, 0, 1, 1, 0, 0, 1, 1, 0};
  int exp_sel_b [4] = '{0, 1, 2, 0};
  int exp_dat_b [4] = '{8'h11, 8'h3C, 8'hA5, 8'h11};

  initial begin
    rst_n = 1'b0;
    en_a = 0; mode_a = 0; sel_a = 0; in_a = 4'b1010; ready_a = 1;
    en_b = 0; mode_b = 0; sel_b = 0; in_b = 24'hA53C11; ready_b = 1;
    en_c = 0; mode_c = 0; sel_c = 0; in_c = 4'b0110; ready_c = 1;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("rst_valid", valid_a, 0);
    check("rst_data", data_a, 0);
    check("rst_sel", osel_a, 0);
    check("rst_wrap", wrap_a, 0);
    check("rst_err", err_a, 0);

    // Manual mode, one select per clock, 1-clock latency.
    en_a = 1; mode_a = 0;
    tick();
    check("man_idle_valid", valid_a, 0);
    for (int i = 0; i < 4; i++) begin
      sel_a = 2'(i);
      tick();
      check($sformatf("man_data[%0d]", i), data_a, in_a[i]);
      check($sformatf("man_sel[%0d]", i), osel_a, i);
      check($sformatf("man_valid[%0d]", i), valid_a, 1);
    end

    // Switch to auto-scan, DWELL=2.
    mode_a = 1;
    tick();
    check("scan_switch_valid", valid_a, 0);
    for (int j = 0; j < 9; j++) begin
      tick();
      check($sformatf("scan_sel[%0d]", j), osel_a, exp_sel_a[j]);
      check($sformatf("scan_data[%0d]", j), data_a, exp_dat_a[j]);
      check($sformatf("scan_wrap[%0d]", j), wrap_a, (j == 7) ? 1 : 0);
    end

    // Backpressure: channel 0 holds its one remaining dwell slot.
    ready_a = 0;
    in_a = 4'b0101;
    for (int j = 0; j < 5; j++) begin
      tick();
      in_a = ~in_a;
      check($sformatf("stall_data[%0d]", j), data_a, 0);
      check($sformatf("stall_sel[%0d]", j), osel_a, 0);
      check($sformatf("stall_valid[%0d]", j), valid_a, 1);
    end
    in_a = 4'b0101;
    ready_a = 1;
    tick();
    check("resume_sel0", osel_a, 0);
    check("resume_data0", data_a, 1);
    tick();
    check("resume_sel1", osel_a, 1);
    check("resume_data1", data_a, 0);
    en_a = 0;
    tick();
    check("dis_valid", valid_a, 0);

    // N_CH=3, W=8: out-of-range select then valid select.
    en_b = 1; mode_b = 0; sel_b = 2'd3;
    tick();
    tick();
    check("err_data", data_b, 8'h00);
    check("err_flag", err_b, 1);
    check("err_sel", osel_b, 3);
    sel_b = 2'd2;
    tick();
    check("ok_data", data_b, 8'hA5);
    check("ok_flag", err_b, 0);
    sel_b = 2'd1;
    tick();
    check("ok_data1", data_b, 8'h3C);

    // N_CH=3 scan wraps at 2, DWELL=1.
    mode_b = 1;
    tick();
    for (int j = 0; j < 4; j++) begin
      tick();
      check($sformatf("b_sel[%0d]", j), osel_b, exp_sel_b[j]);
      check($sformatf("b_data[%0d]", j), data_b, exp_dat_b[j]);
      check($sformatf("b_wrap[%0d]", j), wrap_b, (j == 2) ? 1 : 0);
      check($sformatf("b_err[%0d]", j), err_b, 0);
    end
    mode_b = 0; sel_b = 2'd3;
    tick();
    tick();
    check("err_again", err_b, 1);
    ready_b = 0;

`ifdef SCAN_MUX_MASK_EN
    // Mask 0101, DWELL=1: visit 0,2,0,2.
    mask_c = 4'b0101;
    en_c = 1; mode_c = 1;
    tick();
    for (int j = 0; j < 4; j++) begin
      tick();
      check($sformatf("mask_sel[%0d]", j), osel_c, (j % 2 == 1) ? 2 : 0);
      check($sformatf("mask_data[%0d]", j), data_c, (j % 2 == 1) ? 1 : 0);
      check($sformatf("mask_wrap[%0d]", j), wrap_c, (j % 2 == 1) ? 1 : 0);
    end
    mask_c = 4'b0000;
    for (int j = 0; j < 3; j++) begin
      tick();
      check($sformatf("mask0_valid[%0d]", j), valid_c, 0);
    end
`else
    // DWELL=1, N_CH=4: advance every load.
    en_c = 1; mode_c = 1;
    tick();
    for (int j = 0; j < 5; j++) begin
      tick();
      check($sformatf("c_sel[%0d]", j), osel_c, j % 4);
      check($sformatf("c_data[%0d]", j), data_c, in_c[j % 4]);
      check($sformatf("c_wrap[%0d]", j), wrap_c, (j == 3) ? 1 : 0);
    end
`endif

    // Asynchronous reset in the middle of a stall.
    en_a = 1; mode_a = 1; ready_a = 1; in_a = 4'b1110;
    tick();
    tick();
    tick();
    tick();
    check("pre_rst_sel", osel_a, 1);
    check("pre_rst_data", data_a, 1);
    ready_a = 0;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", valid_a, 0);
    check("arst_data", data_a, 0);
    check("arst_sel", osel_a, 0);
    check("arst_wrap", wrap_a, 0);
    check("arst_err", err_a, 0);
    check("arst_err_b", err_b, 0);
    check("arst_valid_b", valid_b, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
